// File: rtl/note_judge.sv
// note_judge: grades red/blue pad presses against the note sitting in the judge slot.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   red_button, blue_button    raw pad buttons (asynchronous, synchronized here)
//   note_R_judge, note_B_judge note flags of the judge slot from the shifter
//   offset                     pixel counter from the shifter (wrap OFFSET_MAX->0 = slot advance)
//   finish                     song-end level; freezes judging
//   clear                      synchronous counter clear (already synchronized)
//   delete                     one-cycle pulse clearing a hit note from the judge slot
//   result_valid, hit_result   one-cycle grade report: 1 perfect, 2 good, 3 miss
//   combo, max_combo, score    saturating play statistics
module note_judge #(
    parameter logic [2:0]  PERF_LO     = 3'd2,
    parameter logic [2:0]  PERF_HI     = 3'd4,
    parameter logic [15:0] PERFECT_PTS = 16'd3,
    parameter logic [15:0] GOOD_PTS    = 16'd1,
    parameter logic [2:0]  OFFSET_MAX  = 3'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        note_R_judge,
    input  logic        note_B_judge,
    input  logic [2:0]  offset,
    input  logic        finish,
    input  logic        clear,
    output logic        delete,
    output logic        result_valid,
    output logic [1:0]  hit_result,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic [15:0] score
);

    typedef enum logic [1:0] {StEmpty, StArmed, StHit, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  red_sync_q, blue_sync_q;
    logic        red_prev_q, blue_prev_q;
    logic [2:0]  offset_q;
    logic        pend_r_q, pend_r_d;
    logic        pend_b_q, pend_b_d;
    logic        delete_q, delete_d;
    logic        valid_q, valid_d;
    logic [1:0]  result_q, result_d;
    logic [7:0]  combo_q, combo_d;
    logic [7:0]  max_combo_q, max_combo_d;
    logic [15:0] score_q, score_d;

    logic        red_edge, blue_edge;
    logic        press_r, press_b;
    logic        shift_evt, note_present;
    logic        hit, bad_press, perfect;
    logic [7:0]  combo_inc;
    logic [15:0] pts;
    logic [16:0] score_sum;
    logic [15:0] score_sat;

    assign red_edge  = red_sync_q[1] & ~red_prev_q;
    assign blue_edge = blue_sync_q[1] & ~blue_prev_q;
    // A press that landed on a slot-advance cycle is replayed one cycle later on the new note.
    assign press_r   = red_edge | pend_r_q;
    assign press_b   = blue_edge | pend_b_q;

    assign shift_evt    = (offset_q == OFFSET_MAX) && (offset == 3'd0);
    assign note_present = note_R_judge | note_B_judge;

    assign hit       = (press_r & ~press_b & note_R_judge) | (press_b & ~press_r & note_B_judge);
    assign bad_press = (press_r | press_b) & ~hit;
    assign perfect   = (offset >= PERF_LO) && (offset <= PERF_HI);

    assign combo_inc = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
    assign pts       = perfect ? PERFECT_PTS : GOOD_PTS;
    assign score_sum = {1'b0, score_q} + {1'b0, pts};
    assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    always_comb begin
        state_d     = state_q;
        pend_r_d    = 1'b0;
        pend_b_d    = 1'b0;
        delete_d    = 1'b0;
        valid_d     = 1'b0;
        result_d    = 2'd0;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        score_d     = score_q;

        if (finish) begin
            state_d = StDone;
            if (clear) begin
                combo_d     = 8'd0;
                max_combo_d = 8'd0;
                score_d     = 16'd0;
            end
        end else if (state_q == StDone) begin
            if (clear) begin
                state_d     = StEmpty;
                combo_d     = 8'd0;
                max_combo_d = 8'd0;
                score_d     = 16'd0;
            end
        end else if (clear) begin
            state_d     = StEmpty;
            combo_d     = 8'd0;
            max_combo_d = 8'd0;
            score_d     = 16'd0;
        end else if (shift_evt) begin
            if (state_q == StArmed) begin
                valid_d  = 1'b1;
                result_d = 2'd3;
                combo_d  = 8'd0;
            end
            // The slot already shows the next note on this cycle.
            state_d  = note_present ? StArmed : StEmpty;
            pend_r_d = red_edge;
            pend_b_d = blue_edge;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (note_present) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (hit) begin
                        state_d     = StHit;
                        delete_d    = 1'b1;
                        valid_d     = 1'b1;
                        result_d    = perfect ? 2'd1 : 2'd2;
                        score_d     = score_sat;
                        combo_d     = combo_inc;
                        max_combo_d = (combo_inc > max_combo_q) ? combo_inc : max_combo_q;
                    end else if (bad_press) begin
                        combo_d = 8'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            red_sync_q  <= 2'b00;
            blue_sync_q <= 2'b00;
            red_prev_q  <= 1'b0;
            blue_prev_q <= 1'b0;
            offset_q    <= 3'd0;
            pend_r_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            delete_q    <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= 2'd0;
            combo_q     <= 8'd0;
            max_combo_q <= 8'd0;
            score_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            red_sync_q  <= {red_sync_q[0], red_button};
            blue_sync_q <= {blue_sync_q[0], blue_button};
            red_prev_q  <= red_sync_q[1];
            blue_prev_q <= blue_sync_q[1];
            offset_q    <= offset;
            pend_r_q    <= pend_r_d;
            pend_b_q    <= pend_b_d;
            delete_q    <= delete_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            score_q     <= score_d;
        end
    end

    assign delete       = delete_q;
    assign result_valid = valid_q;
    assign hit_result   = result_q;
    assign combo        = combo_q;
    assign max_combo    = max_combo_q;
    assign score        = score_q;

endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: directed song fragments followed by randomized play, every cycle
// compared against a note-level reference model.
module tb_note_judge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        red_button = 1'b0;
    logic        blue_button = 1'b0;
    logic        note_R_judge = 1'b0;
    logic        note_B_judge = 1'b0;
    logic [2:0]  offset = 3'd0;
    logic        finish = 1'b0;
    logic        clear = 1'b0;
    logic        delete;
    logic        result_valid;
    logic [1:0]  hit_result;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [15:0] score;

    always #5 clk = ~clk;

    note_judge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .red_button   (red_button),
        .blue_button  (blue_button),
        .note_R_judge (note_R_judge),
        .note_B_judge (note_B_judge),
        .offset       (offset),
        .finish       (finish),
        .clear        (clear),
        .delete       (delete),
        .result_valid (result_valid),
        .hit_result   (hit_result),
        .combo        (combo),
        .max_combo    (max_combo),
        .score        (score)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a note is either waiting to be hit (live), already graded, or absent.
    bit h_r[3];
    bit h_b[3];
    int prev_off;
    bit m_live, m_graded, m_done, m_pend_r, m_pend_b;
    int m_combo, m_max, m_score;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            h_r[i] = 1'b0;
            h_b[i] = 1'b0;
        end
        prev_off = 0;
        m_live = 0; m_graded = 0; m_done = 0; m_pend_r = 0; m_pend_b = 0;
        m_combo = 0; m_max = 0; m_score = 0;
    endtask

    task automatic zero_counters();
        m_combo = 0;
        m_max   = 0;
        m_score = 0;
    endtask

    // One clock: predict from the inputs currently applied, clock, then compare.
    task automatic tick();
        bit pr, pb, np, sh, hit;
        bit npr, npb;
        bit e_del, e_val;
        int e_res, pts;
        e_del = 0; e_val = 0; e_res = 0; npr = 0; npb = 0;
        // Button level reaches the edge detector two clocks after it is sampled.
        pr = (h_r[1] && !h_r[2]) || m_pend_r;
        pb = (h_b[1] && !h_b[2]) || m_pend_b;
        np = note_R_judge || note_B_judge;
        sh = (prev_off == 6) && (int'(offset) == 0);

        if (finish) begin
            m_done = 1; m_live = 0; m_graded = 0;
            if (clear) zero_counters();
        end else if (m_done) begin
            if (clear) begin
                m_done = 0; m_live = 0; m_graded = 0;
                zero_counters();
            end
        end else if (clear) begin
            m_live = 0; m_graded = 0;
            zero_counters();
        end else if (sh) begin
            if (m_live) begin
                e_val = 1; e_res = 3; m_combo = 0;
            end
            m_live = np; m_graded = 0;
            npr = h_r[1] && !h_r[2];
            npb = h_b[1] && !h_b[2];
        end else if (m_live) begin
            hit = (pr && !pb && note_R_judge) || (pb && !pr && note_B_judge);
            if (hit) begin
                e_del = 1; e_val = 1;
                if (int'(offset) >= 2 && int'(offset) <= 4) begin
                    e_res = 1; pts = 3;
                end else begin
                    e_res = 2; pts = 1;
                end
                m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
                m_combo = (m_combo < 255) ? m_combo + 1 : 255;
                if (m_combo > m_max) m_max = m_combo;
                m_live = 0; m_graded = 1;
            end else if (pr || pb) begin
                m_combo = 0;
            end
        end else if (!m_graded && np) begin
            m_live = 1;
        end

        m_pend_r = npr;
        m_pend_b = npb;
        prev_off = int'(offset);
        h_r[2] = h_r[1]; h_r[1] = h_r[0]; h_r[0] = red_button;
        h_b[2] = h_b[1]; h_b[1] = h_b[0]; h_b[0] = blue_button;

        @(posedge clk);
        #1;
        check_eq("delete", 32'(delete), 32'(e_del));
        check_eq("result_valid", 32'(result_valid), 32'(e_val));
        check_eq("hit_result", 32'(hit_result), 32'(e_res));
        check_eq("combo", 32'(combo), 32'(m_combo));
        check_eq("max_combo", 32'(max_combo), 32'(m_max));
        check_eq("score", 32'(score), 32'(m_score));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        red_button = 1'b0; blue_button = 1'b0;
        note_R_judge = 1'b0; note_B_judge = 1'b0;
        offset = 3'd0; finish = 1'b0; clear = 1'b0;
        #1;
        check_eq("rst_delete", 32'(delete), 32'd0);
        check_eq("rst_result_valid", 32'(result_valid), 32'd0);
        check_eq("rst_hit_result", 32'(hit_result), 32'd0);
        check_eq("rst_combo", 32'(combo), 32'd0);
        check_eq("rst_max_combo", 32'(max_combo), 32'd0);
        check_eq("rst_score", 32'(score), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One slot pass (offset 0..6). nc: 0 none, 1 red, 2 blue. A press graded at offset p is
    // produced by raising the button at offset p-2 for two cycles; colour bit0 red, bit1 blue.
    task automatic play_note(input int nc, input int p1, input int c1, input int p2, input int c2);
        bit rl, bl;
        for (int off = 0; off <= 6; off++) begin
            rl = 0; bl = 0;
            if (p1 >= 2 && (off == p1 - 2 || off == p1 - 1)) begin
                rl = rl | ((c1 & 1) != 0);
                bl = bl | ((c1 & 2) != 0);
            end
            if (p2 >= 2 && (off == p2 - 2 || off == p2 - 1)) begin
                rl = rl | ((c2 & 1) != 0);
                bl = bl | ((c2 & 2) != 0);
            end
            offset = 3'(off);
            note_R_judge = (nc == 1);
            note_B_judge = (nc == 2);
            red_button = rl;
            blue_button = bl;
            tick();
        end
    endtask

    initial begin
        int off, nc;
        bit fin_lvl;
        model_reset();
        do_reset();

        // Perfect red, good blue, then two more perfect reds.
        play_note(1, 3, 1, -1, 0);
        check_eq("first_score", 32'(score), 32'd3);
        check_eq("first_combo", 32'(combo), 32'd1);
        play_note(2, 6, 2, -1, 0);
        check_eq("good_score", 32'(score), 32'd4);
        play_note(1, 3, 1, -1, 0);
        play_note(1, 2, 1, -1, 0);
        check_eq("mid_score", 32'(score), 32'd10);
        check_eq("mid_combo", 32'(combo), 32'd4);

        // Mid-song reset.
        do_reset();

        // Five hits, then an unpressed note becomes a miss at the next advance.
        for (int i = 0; i < 5; i++) play_note(1, 4, 1, -1, 0);
        check_eq("five_combo", 32'(combo), 32'd5);
        play_note(1, -1, 0, -1, 0);
        // Wrong colour then both buttons on a red note.
        play_note(1, 2, 2, 5, 3);
        check_eq("miss_combo", 32'(combo), 32'd0);
        check_eq("miss_max_combo", 32'(max_combo), 32'd5);
        play_note(1, 3, 1, -1, 0);
        check_eq("recover_combo", 32'(combo), 32'd1);
        check_eq("recover_score", 32'(score), 32'd18);

        // Clear, then a long perfect streak to saturate combo.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clear_score", 32'(score), 32'd0);
        for (int i = 0; i < 260; i++) play_note(1, 3, 1, -1, 0);
        check_eq("sat_combo", 32'(combo), 32'd255);
        check_eq("sat_max_combo", 32'(max_combo), 32'd255);
        check_eq("sat_score", 32'(score), 32'd780);

        // Song over: presses ignored, counters frozen until clear.
        finish = 1'b1;
        play_note(1, 3, 1, -1, 0);
        check_eq("done_score", 32'(score), 32'd780);
        finish = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("done_clear_combo", 32'(combo), 32'd0);
        check_eq("done_clear_max", 32'(max_combo), 32'd0);
        check_eq("done_clear_score", 32'(score), 32'd0);
        play_note(2, 4, 2, -1, 0);
        check_eq("after_done_score", 32'(score), 32'd3);

        // Randomized play with an occasionally stalling shifter.
        off = 6;
        nc = 1;
        fin_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) != 0) begin
                if (off == 6) begin
                    off = 0;
                    nc = $urandom_range(0, 6);
                end else begin
                    off++;
                end
            end
            offset = 3'(off);
            note_R_judge = (nc == 2 || nc == 3 || nc == 6);
            note_B_judge = (nc == 4 || nc == 5 || nc == 6);
            if ($urandom_range(0, 3) == 0) red_button = ~red_button;
            if ($urandom_range(0, 3) == 0) blue_button = ~blue_button;
            if (!fin_lvl && $urandom_range(0, 299) == 0) fin_lvl = 1;
            else if (fin_lvl && $urandom_range(0, 9) == 0) fin_lvl = 0;
            finish = fin_lvl;
            clear = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
